// File: rtl/sram_like_pkg.sv
// Shared types and constants for the two-master SRAM-like arbiter.
package sram_like_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_e;

    localparam logic       MID_INST  = 1'b0;
    localparam logic       MID_DATA  = 1'b1;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: on a tie the master that did not win last time is chosen.
module rr_pick2
    import sram_like_pkg::*;
(
    input  logic i_req_inst,
    input  logic i_req_data,
    input  logic i_last_grant,
    output logic o_winner
);

    always_comb begin
        o_winner = i_last_grant;
        if (i_req_inst && i_req_data) begin
            o_winner = ~i_last_grant;
        end else if (i_req_inst) begin
            o_winner = MID_INST;
        end else if (i_req_data) begin
            o_winner = MID_DATA;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates an instruction (read-only) and a data master onto one SRAM-like slave port,
// keeping at most one transaction outstanding.
module sram_like_arbiter
    import sram_like_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_cache,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic        d_cache,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] m_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic        s_cache,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok
);

    state_e r_state;
    state_e w_state_d;
    logic   r_grant;
    logic   w_grant_d;
    logic   r_last_grant;
    logic   w_last_grant_d;
    logic   w_winner;
    logic   w_sel_req;
    logic   w_addr_ok;
    logic   w_data_ok;

    rr_pick2 u_rr_pick2 (
        .i_req_inst   (i_req),
        .i_req_data   (d_req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner)
    );

    assign m_rdata   = s_rdata;
    assign w_sel_req = (r_grant == MID_DATA) ? d_req : i_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= MID_INST;
            r_last_grant <= MID_INST;
        end else begin
            r_state      <= w_state_d;
            r_grant      <= w_grant_d;
            r_last_grant <= w_last_grant_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_grant_d      = r_grant;
        w_last_grant_d = r_last_grant;
        w_addr_ok      = 1'b0;
        w_data_ok      = 1'b0;
        s_req          = 1'b0;
        s_wr           = 1'b0;
        s_size         = 2'b00;
        s_be           = 4'h0;
        s_addr         = 32'h0;
        s_cache        = 1'b0;
        s_wdata        = 32'h0;
        unique case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_grant_d = w_winner;
                    w_state_d = ADDR;
                end
            end
            ADDR: begin
                s_req = w_sel_req;
                if (r_grant == MID_DATA) begin
                    s_wr    = d_wr;
                    s_size  = d_size;
                    s_be    = d_be;
                    s_addr  = d_addr;
                    s_cache = d_cache;
                    s_wdata = d_wdata;
                end else begin
                    s_size  = SIZE_WORD;
                    s_be    = 4'hF;
                    s_addr  = i_addr;
                    s_cache = i_cache;
                end
                // A withdrawn request abandons the access without touching last_grant.
                if (!w_sel_req) begin
                    w_state_d = IDLE;
                end else if (s_addr_ok) begin
                    w_addr_ok = 1'b1;
                    if (s_data_ok) begin
                        w_data_ok      = 1'b1;
                        w_last_grant_d = r_grant;
                        w_state_d      = IDLE;
                    end else begin
                        w_state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (s_data_ok) begin
                    w_data_ok      = 1'b1;
                    w_last_grant_d = r_grant;
                    w_state_d      = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        i_addr_ok = w_addr_ok && (r_grant == MID_INST);
        i_data_ok = w_data_ok && (r_grant == MID_INST);
        d_addr_ok = w_addr_ok && (r_grant == MID_DATA);
        d_data_ok = w_data_ok && (r_grant == MID_DATA);
    end

endmodule
